mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline: consumes the execute stage's `ex_mem_flow_t` and produces `mem_wb_flow_t` for writeback. Loads and stores go through a request/acknowledge data-memory port that may take any number of cycles; a small FSM holds the pipeline via `stall` until the access completes. Non-memory instructions pass through with zero added latency. The stage also drives the MEM-stage forwarding value.

## Interface
Parameters:
- `ADDR_W`, default 32: data-memory address width; must be 32 or less.

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `inflow` in `ex_mem_flow_t`: EX/MEM register contents, with fields `alu_result`, `pc_incr`, `pc_offset`, `immediate`, `rs2_data`, `rd_addr`, `mem_ctrl`, `wb_ctrl`.
- `in_valid` in 1: `inflow` holds a live instruction, not a bubble.
- `outflow` out `mem_wb_flow_t`: fields `alu_result`, `pc_incr`, `mem_data`, `rd_addr`, `wb_ctrl`, `misalign`.
- `out_valid` out 1: `outflow` may be latched by the MEM/WB register this cycle.
- `stall` out 1: to the hazard unit; freezes PC, IF/ID, ID/EX and EX/MEM.
- `fwd_mem_data` out 32: MEM-stage forwarding value.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out `ADDR_W`: word-aligned address.
- `dmem_wstrb` out 4: byte write strobes.
- `dmem_wdata` out 32: store data, lane-replicated.
- `dmem_ack` in 1: one-cycle completion pulse.
- `dmem_rdata` in 32: read word, valid only when `dmem_ack` is 1.

## Operation
- `mem_ctrl` fields used:
  - `MemRead` and `MemWrite`.
  - `MemWidth`: BYTE, HALF or WORD.
  - `MemUnsigned`.
- A memory op is `in_valid & (MemRead | MemWrite)`.
- FSM states: IDLE, REQ, DONE.
  - IDLE:
    - A memory op sets `stall`=1.
    - On the next edge the FSM registers `addr`, `we`, `wstrb` and `wdata`, then moves to REQ.
    - Anything else passes through with `stall`=0 and `out_valid`=`in_valid`.
  - REQ:
    - `dmem_req`=1 and `stall`=1.
    - Bus outputs stay constant until `dmem_ack`.
    - On `dmem_ack`, `dmem_rdata` is captured into `load_buf`, then the FSM moves to DONE.
  - DONE:
    - `stall`=0 and `out_valid`=1.
    - `mem_data` is the extended `load_buf`; it is 0 for stores.
    - Next state is IDLE.
- Store lane steering:
  - BYTE: `wdata`={4{rs2[7:0]}}, `wstrb`=1<<addr[1:0].
  - HALF: `wdata`={2{rs2[15:0]}}, `wstrb`=3<<{addr[1],1'b0}.
  - WORD: `wstrb`=4'hF.
- Load extraction: select the lane with addr[1:0], then sign-extend, or zero-extend when `MemUnsigned`=1.
- `dmem_addr` = {alu_result[ADDR_W-1:2], 2'b00}.
- `fwd_mem_data`:
  - `pc_incr` when `wb_ctrl.MemtoReg`=2.
  - Otherwise `alu_result`.
  - Load data is never forwarded from MEM; the hazard unit handles it.
- `dmem_ack` outside REQ is ignored.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and `load_buf` to 0.
- Non-memory op: 0 cycles of added latency.
- Memory op accepted in cycle T:
  - REQ runs from T+1.
  - With ack in cycle T+k (k≥1), DONE is in T+k+1.
  - `stall` is high for cycles T through T+k, which is k+1 cycles; the minimum total is 2 stall cycles.
- `dmem_ack` in the same cycle the FSM enters REQ is not possible; acks are only sampled while in REQ.
- Reset asserted in REQ:
  - `dmem_req` drops immediately (asynchronous reset).
  - A late ack after reset is ignored.
- `inflow` is guaranteed stable while `stall`=1 because the EX/MEM register is frozen.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A HALF access with addr[0]=1, or a WORD access with addr[1:0]≠0, issues no request and causes no stall.
  - `outflow.misalign`=1.
  - `outflow.wb_ctrl.RegWrite` is forced to 0.
- Not defined:
  - Misaligned accesses are naturally aligned by clearing the offending low bits: addr[0] for HALF, addr[1:0] for WORD.
  - The access then proceeds normally.
  - `outflow.misalign` is tied to 0.

## Structure
- `pipeline_flow_types.sv` holds `mem_width_t` (BYTE, HALF, WORD), `mem_state_t` (IDLE, REQ, DONE), `mem_wb_flow_t`, and the additions to `mem_ctrl_t`.
- Sub-module `load_store_align` is purely combinational. It computes store `wstrb` and `wdata` and load extraction/extension from addr[1:0], width and unsigned.
- The FSM and `load_buf` stay in `mem_stage`.

## Test plan
- ALU op with `alu_result`=0x1234, `in_valid`=1 -> same cycle: `out_valid`=1, `stall`=0, `dmem_req`=0, `fwd_mem_data`=0x1234.
- LW at 0x100, ack 3 cycles after REQ, `rdata`=0xDEADBEEF -> 4 stall cycles, then DONE with `mem_data`=0xDEADBEEF; `dmem_addr`=0x100.
- LB at 0x103 with `rdata`=0x80FF_FF7F -> `mem_data`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x102 with `rs2`=0xAAAA5678 -> `wdata`=0x56785678, `wstrb`=4'b1100, `we`=1; DONE then `mem_data`=0.
- Reset pulse during REQ, followed by a stray `dmem_ack` -> `dmem_req`=0 and FSM in IDLE; no `out_valid` pulse.
- LW at 0x101:
  - With the macro defined -> no `dmem_req`, `misalign`=1, `RegWrite`=0.
  - Without the macro -> `dmem_addr`=0x100 and the access completes.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline flow types for the memory-access stage.
// Contents:
//   mem_width_t    - access width (BYTE, HALF, WORD)
//   mem_state_t    - memory FSM states (IDLE, REQ, DONE)
//   mem_ctrl_t     - memory control bits carried from decode
//   wb_ctrl_t      - writeback control bits
//   ex_mem_flow_t  - EX/MEM register contents
//   mem_wb_flow_t  - MEM/WB register contents
//   lane_offset()  - byte offset actually used inside the word for an access
package mem_stage_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Writeback mux selector value that picks the link address (pc + 4).
    localparam logic [1:0] WB_SEL_PC_INCR = 2'd2;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        mem_width_t mem_width;
        logic       mem_unsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] pc_incr;
        logic [31:0] pc_offset;
        logic [31:0] immediate;
        logic [31:0] rs2_data;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
    } ex_mem_flow_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] pc_incr;
        logic [31:0] mem_data;
        logic [4:0]  rd_addr;
        wb_ctrl_t    wb_ctrl;
        logic        misalign;
    } mem_wb_flow_t;

    // Misaligned halves/words are naturally aligned by dropping the
    // offending low address bits, so only the legal lane offset survives.
    function automatic logic [1:0] lane_offset(input mem_width_t width,
                                               input logic [1:0] addr_lo);
        logic [1:0] off;
        case (width)
            BYTE:    off = addr_lo;
            HALF:    off = {addr_lo[1], 1'b0};
            WORD:    off = 2'b00;
            default: off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// load_store_align: purely combinational byte-lane steering for the data
// memory port.
// Ports:
//   offset      in  2  - byte offset within the word (already aligned)
//   width       in     - access width
//   is_unsigned in  1  - zero-extend loads instead of sign-extending
//   store_data  in  32 - register value to store
//   load_word   in  32 - full word returned by memory
//   wstrb       out 4  - byte write strobes
//   wdata       out 32 - store data replicated across lanes
//   load_data   out 32 - selected and extended load value
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  mem_width_t  width,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store steering: replicate data into every lane, enable only the target lanes.
    always_comb begin
        wstrb = 4'h0;
        wdata = 32'h0;
        case (width)
            BYTE: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            HALF: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {offset[1], 1'b0};
            end
            WORD: begin
                wdata = store_data;
                wstrb = 4'hF;
            end
            default: begin
                wdata = 32'h0;
                wstrb = 4'h0;
            end
        endcase
    end

    // Load lane selection from the returned word.
    always_comb begin
        byte_s = 8'h0;
        half_s = 16'h0;
        case (offset)
            2'd0:    byte_s = load_word[7:0];
            2'd1:    byte_s = load_word[15:8];
            2'd2:    byte_s = load_word[23:16];
            2'd3:    byte_s = load_word[31:24];
            default: byte_s = 8'h0;
        endcase
        if (offset[1]) begin
            half_s = load_word[31:16];
        end else begin
            half_s = load_word[15:0];
        end
    end

    // Load sign/zero extension.
    always_comb begin
        load_data = 32'h0;
        case (width)
            BYTE: begin
                if (is_unsigned) begin
                    load_data = {24'h0, byte_s};
                end else begin
                    load_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            HALF: begin
                if (is_unsigned) begin
                    load_data = {16'h0, half_s};
                end else begin
                    load_data = {{16{half_s[15]}}, half_s};
                end
            end
            WORD:    load_data = load_word;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline. Non-memory
// instructions flow through combinationally; loads and stores run a
// request/acknowledge transaction on the data-memory port while holding
// the front of the pipeline with stall.
// Optional build macro: MEM_MISALIGN_TRAP_EN - misaligned half/word
// accesses are flagged (outflow.misalign) and suppressed instead of being
// naturally aligned.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   inflow/in_valid - EX/MEM register contents and live flag
//   outflow/out_valid - MEM/WB contents and latch enable
//   stall           - freezes PC, IF/ID, ID/EX, EX/MEM
//   fwd_mem_data    - MEM-stage forwarding value (never load data)
//   dmem_*          - data-memory request/ack port
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_flow_t      inflow,
    input  logic              in_valid,
    output mem_wb_flow_t      outflow,
    output logic              out_valid,
    output logic              stall,
    output logic [31:0]       fwd_mem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_wstrb,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    mem_state_t        state_r;
    mem_state_t        next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [3:0]        wstrb_r;
    logic [31:0]       wdata_r;
    logic              req_r;
    logic [31:0]       load_buf_r;

    logic              mem_op_s;
    logic              misalign_s;
    logic              start_s;
    logic [1:0]        lane_off_s;
    logic [3:0]        wstrb_s;
    logic [31:0]       wdata_s;
    logic [31:0]       load_data_s;
    logic              unused_s;

    // Branch-target and immediate fields are consumed in earlier stages only.
    assign unused_s = ^{inflow.pc_offset, inflow.immediate};

    assign mem_op_s   = in_valid & (inflow.mem_ctrl.mem_read | inflow.mem_ctrl.mem_write);
    assign lane_off_s = lane_offset(inflow.mem_ctrl.mem_width, inflow.alu_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = mem_op_s &
        (((inflow.mem_ctrl.mem_width == HALF) & inflow.alu_result[0]) |
         ((inflow.mem_ctrl.mem_width == WORD) & (inflow.alu_result[1:0] != 2'b00)));
`else
    assign misalign_s = 1'b0;
`endif

    assign start_s = (state_r == IDLE) & mem_op_s & ~misalign_s;

    load_store_align u_align (
        .offset      (lane_off_s),
        .width       (inflow.mem_ctrl.mem_width),
        .is_unsigned (inflow.mem_ctrl.mem_unsigned),
        .store_data  (inflow.rs2_data),
        .load_word   (load_buf_r),
        .wstrb       (wstrb_s),
        .wdata       (wdata_s),
        .load_data   (load_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; acks are only honoured while a request is open.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = REQ;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Bus registers: captured once at accept and held until the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= {ADDR_W{1'b0}};
            we_r    <= 1'b0;
            wstrb_r <= 4'h0;
            wdata_r <= 32'h0;
        end else if (start_s) begin
            addr_r  <= {inflow.alu_result[ADDR_W-1:2], 2'b00};
            we_r    <= inflow.mem_ctrl.mem_write;
            wstrb_r <= inflow.mem_ctrl.mem_write ? wstrb_s : 4'h0;
            wdata_r <= inflow.mem_ctrl.mem_write ? wdata_s : 32'h0;
        end
    end

    // Request valid: raised on accept, dropped on ack (and asynchronously on reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= 1'b0;
        end else if (start_s) begin
            req_r <= 1'b1;
        end else if ((state_r == REQ) && dmem_ack) begin
            req_r <= 1'b0;
        end
    end

    // Read data is only valid alongside the ack, so it is captured then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_buf_r <= 32'h0;
        end else if ((state_r == REQ) && dmem_ack) begin
            load_buf_r <= dmem_rdata;
        end
    end

    assign dmem_req   = req_r;
    assign dmem_we    = we_r;
    assign dmem_addr  = addr_r;
    assign dmem_wstrb = wstrb_r;
    assign dmem_wdata = wdata_r;

    // Stage outputs: pass-through in IDLE, hold during REQ, result in DONE.
    always_comb begin
        stall               = 1'b0;
        out_valid           = 1'b0;
        outflow.alu_result  = inflow.alu_result;
        outflow.pc_incr     = inflow.pc_incr;
        outflow.mem_data    = 32'h0;
        outflow.rd_addr     = inflow.rd_addr;
        outflow.wb_ctrl     = inflow.wb_ctrl;
        outflow.misalign    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_op_s && !misalign_s) begin
                    stall = 1'b1;
                end else begin
                    out_valid = in_valid;
                    if (misalign_s) begin
                        outflow.misalign          = 1'b1;
                        outflow.wb_ctrl.reg_write = 1'b0;
                    end else begin
                        outflow.misalign = 1'b0;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (inflow.mem_ctrl.mem_read) begin
                    outflow.mem_data = load_data_s;
                end else begin
                    outflow.mem_data = 32'h0;
                end
            end
            default: begin
                stall     = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Forwarding value: link address for jumps, otherwise the ALU result.
    always_comb begin
        if (inflow.wb_ctrl.mem_to_reg == WB_SEL_PC_INCR) begin
            fwd_mem_data = inflow.pc_incr;
        end else begin
            fwd_mem_data = inflow.alu_result;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by random
// loads, stores and ALU ops compared with a byte-lane reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk;
    logic         rst;
    ex_mem_flow_t inflow;
    logic         in_valid;
    mem_wb_flow_t outflow;
    logic         out_valid;
    logic         stall;
    logic [31:0]  fwd_mem_data;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [3:0]   dmem_wstrb;
    logic [31:0]  dmem_wdata;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .inflow       (inflow),
        .in_valid     (in_valid),
        .outflow      (outflow),
        .out_valid    (out_valid),
        .stall        (stall),
        .fwd_mem_data (fwd_mem_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input mem_width_t w);
        return (w == BYTE) ? 1 : ((w == HALF) ? 2 : 4);
    endfunction

    // Reference: pick sz bytes starting at the aligned byte index, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input int idx,
                                               input int sz, input logic uns);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v = (word >> (8 * idx)) & mask;
        if (!uns && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        inflow   = '0;
        #1;
        check("idle_stall", {31'b0, stall}, 32'd0);
        check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [31:0] pci, input logic [1:0] m2r);
        @(posedge clk); #1;
        inflow = '0;
        inflow.alu_result         = alu;
        inflow.pc_incr            = pci;
        inflow.rd_addr            = 5'($urandom);
        inflow.wb_ctrl.reg_write  = 1'b1;
        inflow.wb_ctrl.mem_to_reg = m2r;
        in_valid = 1'b1;
        #1;
        check("alu_out_valid", {31'b0, out_valid}, 32'd1);
        check("alu_stall", {31'b0, stall}, 32'd0);
        check("alu_req", {31'b0, dmem_req}, 32'd0);
        check("alu_fwd", fwd_mem_data, (m2r == 2'd2) ? pci : alu);
        check("alu_result", outflow.alu_result, alu);
        check("alu_mem_data", outflow.mem_data, 32'd0);
    endtask

    task automatic mem_access(input logic is_load, input logic uns, input mem_width_t w,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input logic [31:0] rdata, input int k);
        ex_mem_flow_t f;
        int sz, idx, stalls;
        bit mis;
        logic [3:0]  exp_st;
        logic [31:0] exp_wd;
        f = '0;
        f.alu_result            = addr;
        f.pc_incr               = addr + 32'd4;
        f.rs2_data              = rs2;
        f.rd_addr               = 5'($urandom);
        f.mem_ctrl.mem_read     = is_load;
        f.mem_ctrl.mem_write    = ~is_load;
        f.mem_ctrl.mem_width    = w;
        f.mem_ctrl.mem_unsigned = uns;
        f.wb_ctrl.reg_write     = is_load;
        f.wb_ctrl.mem_to_reg    = is_load ? 2'd1 : 2'd0;
        sz  = size_of(w);
        mis = (addr % sz) != 0;
        idx = ((addr % 4) / sz) * sz;
        exp_st = 4'h0;
        exp_wd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= idx && i < idx + sz) exp_st[i] = 1'b1;
            exp_wd[8 * i +: 8] = rs2[8 * (i % sz) +: 8];
        end
        @(posedge clk); #1;
        inflow   = f;
        in_valid = 1'b1;
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (mis) begin
            check("mis_out_valid", {31'b0, out_valid}, 32'd1);
            check("mis_stall", {31'b0, stall}, 32'd0);
            check("mis_flag", {31'b0, outflow.misalign}, 32'd1);
            check("mis_regwrite", {31'b0, outflow.wb_ctrl.reg_write}, 32'd0);
            @(posedge clk); #1;
            check("mis_no_req", {31'b0, dmem_req}, 32'd0);
            in_valid = 1'b0;
            return;
        end
`endif
        check("acc_stall", {31'b0, stall}, 32'd1);
        check("acc_out_valid", {31'b0, out_valid}, 32'd0);
        check("acc_req_early", {31'b0, dmem_req}, 32'd0);
        stalls = 1;
        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            if (stall) stalls++;
            check("req_req", {31'b0, dmem_req}, 32'd1);
            check("req_out_valid", {31'b0, out_valid}, 32'd0);
            check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_we", {31'b0, dmem_we}, {31'b0, ~is_load});
            if (!is_load) begin
                check("req_wstrb", {28'b0, dmem_wstrb}, {28'b0, exp_st});
                check("req_wdata", dmem_wdata, exp_wd);
            end
            if (c == k) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        #1;
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_out_valid", {31'b0, out_valid}, 32'd1);
        check("done_mem_data", outflow.mem_data,
              is_load ? model_load(rdata, idx, sz, uns) : 32'd0);
        check("done_rd", {27'b0, outflow.rd_addr}, {27'b0, f.rd_addr});
        check("done_misalign", {31'b0, outflow.misalign}, 32'd0);
        check("stall_cycles", stalls, k + 1);
        idle_cycle();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        inflow     = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_we", {31'b0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wstrb", {28'b0, dmem_wstrb}, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_fwd", fwd_mem_data, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;

        // Directed cases
        alu_op(32'h0000_1234, 32'h0000_0040, 2'd0);
        alu_op(32'h0000_5555, 32'h0000_0044, 2'd2);
        mem_access(1'b1, 1'b0, WORD, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        mem_access(1'b1, 1'b0, BYTE, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 1);
        mem_access(1'b1, 1'b1, BYTE, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2);
        mem_access(1'b0, 1'b0, HALF, 32'h0000_0102, 32'hAAAA_5678, 32'h0, 1);
        mem_access(1'b1, 1'b0, WORD, 32'h0000_0101, 32'h0, 32'h1357_9BDF, 1);

        // Reset while a request is open, then a stray ack
        @(posedge clk); #1;
        inflow = '0;
        inflow.alu_result          = 32'h0000_0200;
        inflow.mem_ctrl.mem_read   = 1'b1;
        inflow.mem_ctrl.mem_width  = WORD;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("rq_req_open", {31'b0, dmem_req}, 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rq_req_dropped", {31'b0, dmem_req}, 32'd0);
        check("rq_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("stray_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        #1;
        check("stray_req", {31'b0, dmem_req}, 32'd0);
        check("stray_out_valid2", {31'b0, out_valid}, 32'd0);
        check("stray_stall", {31'b0, stall}, 32'd0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                alu_op($urandom, $urandom, 2'($urandom_range(0, 2)));
            end else begin
                mem_access(kind == 1, 1'($urandom), mem_width_t'($urandom_range(0, 2)),
                           $urandom, $urandom, $urandom, $urandom_range(1, 4));
            end
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
